fan_speed_ctrl: RTL and testbench

//  Closed-loop fan governor; the consumer/producer on the other end of the fan interface.
//  - Consumes the per-window tach RPM count produced at top level (fan_rpm).
//  - Drives the 10-bit PWM duty word (fan_speed) back to the PWM generator.
//  - Sits inside Top between the host-programmed target and io_fan_speed/io_fan_rpm.
//  - Adds kick-start, stall detection with bounded retries, and a sticky fault.

---
 rtl/fan_speed_ctrl_if.sv | 22 ++
 rtl/fan_speed_ctrl.sv | 156 +++++++++++++++
 tb/tb_fan_speed_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fan_speed_ctrl_if.sv
// Fan governor bus: host enable/target, tach sample in, duty/status out.
// master = host/tach side, slave = fan_speed_ctrl.
interface fan_speed_ctrl_if;
  logic        enable;
  logic [15:0] target_rpm;
  logic [15:0] rpm;
  logic        rpm_valid;
  logic [9:0]  duty;
  logic        stall;
  logic        fault;
  logic [2:0]  state;

  modport master (
    output enable, target_rpm, rpm, rpm_valid,
    input  duty, stall, fault, state
  );

  modport slave (
    input  enable, target_rpm, rpm, rpm_valid,
    output duty, stall, fault, state
  );
endinterface

// File: rtl/fan_speed_ctrl.sv
// Closed-loop fan governor: kick-start, proportional duty, stall retry, fault.
// Ports: clock, reset_n (async low), fan (fan_speed_ctrl_if.slave).
// Option: FAN_CTRL_DEADBAND_EN holds duty while |err| <= DEADBAND.
module fan_speed_ctrl #(
  parameter int GAIN_SHIFT    = 4,
  parameter int MIN_DUTY      = 128,
  parameter int KICK_CYCLES   = 5000000,
  parameter int STALL_SAMPLES = 3,
  parameter int MAX_RETRIES   = 3,
  parameter int DEADBAND      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  fan_speed_ctrl_if.slave  fan
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] KICK     = 3'd1;
  localparam logic [2:0] REGULATE = 3'd2;
  localparam logic [2:0] FAULT    = 3'd3;

  localparam int KW = (KICK_CYCLES > 1) ? $clog2(KICK_CYCLES) : 1;
  localparam int ZW = $clog2(STALL_SAMPLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);

  localparam logic [KW-1:0] KLAST = KW'(KICK_CYCLES - 1);
  localparam logic [ZW-1:0] ZLAST = ZW'(STALL_SAMPLES - 1);
  localparam logic [RW-1:0] RMAX  = RW'(MAX_RETRIES);

  localparam logic [9:0] DMIN = 10'(MIN_DUTY);
  localparam logic [9:0] DMAX = 10'd1023;

  localparam logic signed [17:0] NMIN = 18'(MIN_DUTY);
  localparam logic signed [17:0] NMAX = 18'sd1023;
  localparam logic [16:0]        DBW  = 17'(DEADBAND);

`ifdef FAN_CTRL_DEADBAND_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  logic [2:0]    state_q;
  logic [9:0]    duty_q;
  logic          stall_q;
  logic          fault_q;
  logic [KW-1:0] kcnt_q;
  logic [ZW-1:0] zcnt_q;
  logic [RW-1:0] retry_q;

  logic signed [16:0] err;
  logic signed [16:0] step;
  logic signed [17:0] nd;
  logic [16:0]        mag;
  logic [9:0]         duty_adj;
  logic               zero;
  logic               stall_hit;

  // Both operands are unsigned 16-bit, so 17 bits hold any difference
  // and the 18-bit sum cannot overflow before clamping.
  always_comb begin
    err      = $signed({1'b0, fan.target_rpm}) - $signed({1'b0, fan.rpm});
    step     = err >>> GAIN_SHIFT;
    nd       = $signed({8'd0, duty_q}) + $signed({step[16], step});
    mag      = err[16] ? 17'(-err) : 17'(err);
    duty_adj = nd[9:0];
    if (nd < NMIN)
      duty_adj = DMIN;
    else if (nd > NMAX)
      duty_adj = DMAX;
    if (DB_EN && (mag <= DBW))
      duty_adj = duty_q;
    zero      = (fan.rpm == 16'd0);
    stall_hit = zero && (zcnt_q == ZLAST);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      duty_q  <= '0;
      stall_q <= 1'b0;
      fault_q <= 1'b0;
      kcnt_q  <= '0;
      zcnt_q  <= '0;
      retry_q <= '0;
    end else if (!fan.enable) begin
      state_q <= IDLE;
      duty_q  <= '0;
      stall_q <= 1'b0;
      fault_q <= 1'b0;
      kcnt_q  <= '0;
      zcnt_q  <= '0;
      retry_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          duty_q <= '0;
          if (fan.target_rpm != 16'd0) begin
            state_q <= KICK;
            duty_q  <= DMAX;
            kcnt_q  <= '0;
          end
        end
        KICK: begin
          if (fan.target_rpm == 16'd0) begin
            state_q <= IDLE;
            duty_q  <= '0;
          end else if (kcnt_q == KLAST) begin
            state_q <= REGULATE;
            duty_q  <= DMIN;
            zcnt_q  <= '0;
          end else begin
            kcnt_q <= kcnt_q + KW'(1);
          end
        end
        REGULATE: begin
          if (fan.target_rpm == 16'd0) begin
            state_q <= IDLE;
            duty_q  <= '0;
          end else if (fan.rpm_valid) begin
            if (stall_hit) begin
              stall_q <= 1'b1;
              retry_q <= retry_q + RW'(1);
              duty_q  <= DMAX;
              zcnt_q  <= '0;
              kcnt_q  <= '0;
              if (retry_q < RMAX) begin
                state_q <= KICK;
              end else begin
                state_q <= FAULT;
                fault_q <= 1'b1;
              end
            end else begin
              duty_q <= duty_adj;
              zcnt_q <= zero ? zcnt_q + ZW'(1) : '0;
            end
          end
        end
        FAULT: begin
          duty_q  <= DMAX;
          fault_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          duty_q  <= '0;
        end
      endcase
    end
  end

  assign fan.duty  = duty_q;
  assign fan.stall = stall_q;
  assign fan.fault = fault_q;
  assign fan.state = state_q;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Directed bench for fan_speed_ctrl with a 20-cycle kick.
// Table of regulation vectors plus hand sequences for kick/stall/reset.
module tb_fan_speed_ctrl;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  fan_speed_ctrl_if bus ();

  fan_speed_ctrl #(
    .KICK_CYCLES(20)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .fan    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] tgt;
    logic [15:0] rpm;
    logic [9:0]  duty;
  } vec_t;

  vec_t v[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [15:0] tgt, input logic [15:0] r);
    @(negedge clock);
    bus.target_rpm = tgt;
    bus.rpm        = r;
    bus.rpm_valid  = 1'b1;
    @(negedge clock);
    bus.rpm_valid  = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    for (int i = 0; i < 200; i++) begin
      if (bus.state == s) break;
      @(negedge clock);
    end
    chk(name, 32'(bus.state), 32'(s));
  endtask

  // rpm_valid is held high with rpm=0 for the whole kick, including the
  // KICK->REGULATE edge: it must be ignored and must not count as stall.
  task automatic kick_start();
    int cnt;
    @(negedge clock);
    bus.enable     = 1'b1;
    bus.target_rpm = 16'd2000;
    bus.rpm        = 16'd0;
    bus.rpm_valid  = 1'b1;
    cnt = 0;
    @(negedge clock);
    while (bus.duty == 10'd1023 && cnt < 100) begin
      cnt++;
      @(negedge clock);
    end
    bus.rpm_valid = 1'b0;
    chk("kick_len", 32'(cnt), 32'd20);
    chk("kick_end_duty", 32'(bus.duty), 32'd128);
    chk("kick_end_state", 32'(bus.state), 32'd2);
    chk("kick_end_stall", 32'(bus.stall), 32'd0);
  endtask

  initial begin
    v[0] = '{16'd2000,  16'd1000,  10'd190};
    v[1] = '{16'd100,   16'd5000,  10'd128};
    v[2] = '{16'd65535, 16'd0,     10'd1023};
    v[3] = '{16'd1000,  16'd65535, 10'd128};
    v[4] = '{16'd3000,  16'd248,   10'd300};
    v[5] = '{16'd3000,  16'd2990,  10'd300};
    v[6] = '{16'd3000,  16'd2968,  10'd302};
    v[7] = '{16'd1000,  16'd1100,  10'd295};

    reset_n        = 1'b0;
    bus.enable     = 1'b0;
    bus.target_rpm = 16'd0;
    bus.rpm        = 16'd0;
    bus.rpm_valid  = 1'b0;
    #23;
    chk("rst_duty", 32'(bus.duty), 32'd0);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    kick_start();

    for (int i = 0; i < 8; i++) begin
      strobe(v[i].tgt, v[i].rpm);
      chk($sformatf("vec%0d_duty", i), 32'(bus.duty), 32'(v[i].duty));
      chk($sformatf("vec%0d_state", i), 32'(bus.state), 32'd2);
      chk($sformatf("vec%0d_stall", i), 32'(bus.stall), 32'd0);
    end

    @(negedge clock);
    bus.target_rpm = 16'd0;
    @(negedge clock);
    chk("tgt0_state", 32'(bus.state), 32'd0);
    chk("tgt0_duty", 32'(bus.duty), 32'd0);

    kick_start();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) strobe(16'd2000, 16'd0);
      chk($sformatf("stall%0d_flag", r), 32'(bus.stall), 32'd1);
      chk($sformatf("stall%0d_state", r), 32'(bus.state), 32'd1);
      chk($sformatf("stall%0d_duty", r), 32'(bus.duty), 32'd1023);
      chk($sformatf("stall%0d_fault", r), 32'(bus.fault), 32'd0);
      wait_state(3'd2, $sformatf("rekick%0d_reg", r));
    end
    for (int k = 0; k < 3; k++) strobe(16'd2000, 16'd0);
    repeat (3) @(negedge clock);
    chk("fault_state", 32'(bus.state), 32'd3);
    chk("fault_duty", 32'(bus.duty), 32'd1023);
    chk("fault_flag", 32'(bus.fault), 32'd1);
    chk("fault_stall", 32'(bus.stall), 32'd1);

    bus.enable = 1'b0;
    @(negedge clock);
    chk("dis_duty", 32'(bus.duty), 32'd0);
    chk("dis_fault", 32'(bus.fault), 32'd0);
    chk("dis_stall", 32'(bus.stall), 32'd0);
    chk("dis_state", 32'(bus.state), 32'd0);

    bus.enable     = 1'b1;
    bus.target_rpm = 16'd2000;
    repeat (5) @(negedge clock);
    chk("mid_kick_state", 32'(bus.state), 32'd1);
    chk("mid_kick_duty", 32'(bus.duty), 32'd1023);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_duty", 32'(bus.duty), 32'd0);
    chk("async_rst_state", 32'(bus.state), 32'd0);
    @(negedge clock);
    bus.enable = 1'b0;
    reset_n    = 1'b1;
    @(negedge clock);
    chk("post_rst_state", 32'(bus.state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
